// File: rtl/spi_master_arbiter_if.sv
// Client-side bus of the SPI byte-engine arbiter: per-requester request/lock/data in,
// one-hot grant/done and the shared received byte out.
interface spi_master_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic [DATA_WIDTH-1:0]         rx_data;
  logic                          arb_busy;

  // Handshake: a requester holds req high (level) until it sees its done pulse; the
  // arbiter owns the engine from gnt until done, and rx_data/err are valid with done.
  modport slave (
    input  req, lock, tx_data,
    output gnt, done, err, rx_data, arb_busy
  );

  modport master (
    output req, lock, tx_data,
    input  gnt, done, err, rx_data, arb_busy
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one spi_master byte engine among NUM_REQ clients,
// sequencing start/busy-rise/busy-fall per byte with optional locked bursts.
module spi_master_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_arbiter_if.slave   bus,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_data_in,
  input  logic [DATA_WIDTH-1:0] spi_data_out,
  input  logic                  spi_busy,
  output logic [2:0]            dbg_state
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [IDX_W-1:0]      r_last;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_to;

  logic [IDX_W-1:0]      w_pick;
  logic                  w_pick_vld;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_tx_idx;
  logic [DATA_WIDTH-1:0] w_tx_byte;
  logic                  w_keep;
  logic                  w_timeout;

  // Search descends so the candidate closest after r_last is the one left standing.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (bus.req[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  // While busy, r_last is the owner; a locked burst reloads the owner's slice.
  assign w_keep    = (r_state == S_DONE) && bus.lock[r_last] && bus.req[r_last];
  assign w_tx_idx  = (r_state == S_DONE) ? r_last : w_pick;
  assign w_tx_byte = bus.tx_data[int'(w_tx_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:      if (w_pick_vld) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // The counter reaches BUSY_TIMEOUT-1 on this edge: give up on the engine.
        if (spi_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 2)) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end
      end
      S_WAIT_DONE: if (!spi_busy) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = w_keep ? S_START : S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_data_in <= '0;
      r_rx      <= '0;
      r_cnt     <= '0;
      r_to      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_gnt     <= NUM_REQ'(1) << w_pick;
            r_data_in <= w_tx_byte;
            r_last    <= w_pick;
          end
        end
        S_START: begin
          r_cnt <= '0;
          r_to  <= 1'b0;
        end
        S_WAIT_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) r_to <= 1'b1;
        end
        S_WAIT_DONE: begin
          if (!spi_busy) r_rx <= spi_data_out;
        end
        S_DONE: begin
          if (w_keep) r_data_in <= w_tx_byte;
          else        r_gnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = (r_state == S_DONE) ? r_gnt : '0;
  assign bus.err      = (r_state == S_DONE) && r_to;
  assign bus.rx_data  = r_rx;
  assign bus.arb_busy = (r_state != S_IDLE);
  assign spi_start    = (r_state == S_START);
  assign spi_data_in  = r_data_in;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a loopback byte-engine model and a
// queue-based scoreboard checked by an independent monitor.
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BT = 16;
  localparam int EW = 2 + NR + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  logic          spi_start;
  logic          spi_busy;
  logic [DW-1:0] spi_data_in;
  logic [DW-1:0] spi_data_out;
  logic [2:0]    dbg_state;

  spi_master_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_busy     (spi_busy),
    .dbg_state    (dbg_state)
  );

  // Byte-engine model: busy one cycle after start for 5 cycles, MISO looped to MOSI.
  logic          stub;
  logic [3:0]    m_cnt;
  logic [DW-1:0] m_shift;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy     <= 1'b0;
      m_cnt        <= '0;
      m_shift      <= '0;
      spi_data_out <= '0;
    end else if (spi_busy) begin
      if (m_cnt == 4'd1) begin
        spi_busy     <= 1'b0;
        spi_data_out <= m_shift;
      end
      m_cnt <= m_cnt - 4'd1;
    end else if (spi_start && !stub) begin
      spi_busy <= 1'b1;
      m_cnt    <= 4'd5;
      m_shift  <= spi_data_in;
    end
  end

  // Scoreboard entry: {direct, err, owner one-hot, rx byte}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int n_checks = 0;
  int n_pass   = 0;
  int stim_to  = 0;
  bit stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req_v, $time);
  endtask

  task automatic push_exp(input int owner, input logic [DW-1:0] rx, input bit err, input bit direct);
    logic [NR-1:0] oh;
    oh = '0;
    oh[owner] = 1'b1;
    exp_q.push_back({direct, err, oh, rx});
  endtask

  // Monitor
  int mcyc = 0;
  int start_cyc = 0;
  int fall_cyc = 0;
  int n_start = 0;
  bit saw_idle = 1'b0;
  bit prev_busy = 1'b0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk("reset_outputs", 32'({bus.gnt, bus.done, bus.err, bus.rx_data, bus.arb_busy,
                                spi_start, spi_data_in, dbg_state}), 32'd0);
      n_start   = 0;
      saw_idle  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      mcyc++;
      if (dbg_state == 3'd0) saw_idle = 1'b1;
      if (spi_start) begin
        n_start++;
        start_cyc = mcyc;
      end
      if (prev_busy && !spi_busy) fall_cyc = mcyc;
      prev_busy = spi_busy;
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_owner", 32'(bus.done), 32'(e[DW+NR-1:DW]));
          chk("gnt_owner", 32'(bus.gnt), 32'(e[DW+NR-1:DW]));
          chk("err", 32'(bus.err), 32'(e[DW+NR]));
          chk("rx_data", 32'(bus.rx_data), 32'(e[DW-1:0]));
          chk("start_pulses", n_start, 1);
          chk("idle_between", 32'(saw_idle), 32'(!e[DW+NR+1]));
          if (e[DW+NR]) chk("timeout_latency", mcyc - start_cyc, BT);
          else          chk("done_after_busy_fall", mcyc - fall_cyc, 1);
        end
        n_start  = 0;
        saw_idle = 1'b0;
      end
      if (stim_done) begin
        chk("stim_timeouts", stim_to, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  // Requester driver state
  logic [DW-1:0] tab[NR][3];
  int pend[NR];
  int pos[NR];

  task automatic request(input int i, input int n, input logic [DW-1:0] b0,
                         input logic [DW-1:0] b1, input logic [DW-1:0] b2, input bit lk);
    tab[i][0] = b0;
    tab[i][1] = b1;
    tab[i][2] = b2;
    pos[i]    = 0;
    pend[i]   = n;
    bus.tx_data[i*DW +: DW] = b0;
    bus.req[i]  = 1'b1;
    bus.lock[i] = lk;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n && bus.done != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (bus.done[i] && pend[i] > 0) begin
          pend[i]--;
          pos[i]++;
          if (pend[i] == 0) begin
            bus.req[i]  = 1'b0;
            bus.lock[i] = 1'b0;
          end else begin
            bus.tx_data[i*DW +: DW] = tab[i][pos[i]];
          end
        end
      end
    end
  endtask

  task automatic wait_gnt(input int i, input int budget);
    int k;
    k = 0;
    while (!bus.gnt[i] && k < budget) begin
      tick();
      k++;
    end
    if (!bus.gnt[i]) begin
      stim_to++;
      $display("FAIL wait_gnt: requester %0d not granted within %0d cycles", i, budget);
    end
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (dbg_state == 3'd0) && (bus.gnt == '0);
    for (int i = 0; i < NR; i++) if (pend[i] != 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_quiet(input int budget);
    int k;
    k = 0;
    while (!all_quiet() && k < budget) begin
      tick();
      k++;
    end
    if (!all_quiet()) begin
      stim_to++;
      $display("FAIL wait_quiet: arbiter not idle within %0d cycles", budget);
    end
  endtask

  task automatic clear_drv();
    bus.req     = '0;
    bus.lock    = '0;
    bus.tx_data = '0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0;
      pos[i]  = 0;
    end
  endtask

  // Called right after a negedge so the reset lands mid low phase.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    clear_drv();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    stub = 1'b0;
    clear_drv();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single byte loopback
    request(0, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
    push_exp(0, 8'hA5, 1'b0, 1'b0);
    wait_quiet(200);

    // Simultaneous requests after reset, then all four with two bytes each
    do_reset();
    request(0, 1, 8'h10, 8'h00, 8'h00, 1'b0);
    request(2, 1, 8'h20, 8'h00, 8'h00, 1'b0);
    push_exp(0, 8'h10, 1'b0, 1'b0);
    push_exp(2, 8'h20, 1'b0, 1'b0);
    wait_quiet(200);
    for (int i = 0; i < NR; i++)
      request(i, 2, 8'(8'h30 + i), 8'(8'h40 + i), 8'h00, 1'b0);
    push_exp(3, 8'h33, 1'b0, 1'b0);
    push_exp(0, 8'h30, 1'b0, 1'b0);
    push_exp(1, 8'h31, 1'b0, 1'b0);
    push_exp(2, 8'h32, 1'b0, 1'b0);
    push_exp(3, 8'h43, 1'b0, 1'b0);
    push_exp(0, 8'h40, 1'b0, 1'b0);
    push_exp(1, 8'h41, 1'b0, 1'b0);
    push_exp(2, 8'h42, 1'b0, 1'b0);
    wait_quiet(800);

    // Locked three-byte burst with requester 0 waiting
    request(1, 3, 8'h11, 8'h22, 8'h33, 1'b1);
    wait_gnt(1, 20);
    request(0, 1, 8'h0F, 8'h00, 8'h00, 1'b0);
    push_exp(1, 8'h11, 1'b0, 1'b0);
    push_exp(1, 8'h22, 1'b0, 1'b1);
    push_exp(1, 8'h33, 1'b0, 1'b1);
    push_exp(0, 8'h0F, 1'b0, 1'b0);
    wait_quiet(300);

    // Engine never goes busy: timeout, rx_data keeps the previous byte
    stub = 1'b1;
    request(3, 1, 8'h77, 8'h00, 8'h00, 1'b0);
    push_exp(3, 8'h0F, 1'b1, 1'b0);
    wait_quiet(100);
    stub = 1'b0;

    // Reset during WAIT_DONE, then fresh arbitration from requester 0
    request(1, 1, 8'h55, 8'h00, 8'h00, 1'b0);
    k = 0;
    while (dbg_state != 3'd3 && k < 50) begin
      tick();
      k++;
    end
    if (dbg_state != 3'd3) begin
      stim_to++;
      $display("FAIL wait_state: WAIT_DONE not reached");
    end
    do_reset();
    request(0, 1, 8'h50, 8'h00, 8'h00, 1'b0);
    request(2, 1, 8'h52, 8'h00, 8'h00, 1'b0);
    push_exp(0, 8'h50, 1'b0, 1'b0);
    push_exp(2, 8'h52, 1'b0, 1'b0);
    wait_quiet(200);

    // Requester 2 drops req one cycle after grant; transfer still completes
    request(2, 1, 8'h66, 8'h00, 8'h00, 1'b0);
    wait_gnt(2, 20);
    tick();
    bus.req[2] = 1'b0;
    pend[2]    = 0;
    request(1, 1, 8'h61, 8'h00, 8'h00, 1'b0);
    push_exp(2, 8'h66, 1'b0, 1'b0);
    push_exp(1, 8'h61, 1'b0, 1'b0);
    wait_quiet(200);

    repeat (3) @(negedge clk);
    stim_done = 1'b1;
  end
endmodule
